// File: rtl/task_sched_pkg.sv
// Shared types and constants for the round-robin task dispatcher.
package task_sched_pkg;

    localparam int TASK_W = 8;

    typedef enum logic {IDLE, OFFER} state_e;

    // Queue-ID width: smallest w with 2^w >= n, and at least 1.
    function automatic int qid_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority search. It can optionally hold the previous grant.
module rr_arbiter
    import task_sched_pkg::*;
#(
    parameter int NUM_Q = 4,
    parameter int QID_W = 2
) (
    input  logic [NUM_Q-1:0] eligible_i,
    input  logic [QID_W-1:0] last_grant_i,
    input  logic             hold_i,
    output logic [QID_W-1:0] grant_o,
    output logic             grant_valid_o
);

    int               idx;
    logic [QID_W-1:0] idx_w;

    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        idx_w         = '0;
        // Walk from the farthest offset down to +1 so the nearest eligible queue wins.
        // Offset NUM_Q wraps back onto last_grant itself.
        for (int k = NUM_Q; k >= 1; k--) begin
            idx = int'(last_grant_i) + k;
            if (idx >= NUM_Q) idx = idx - NUM_Q;
            idx_w = QID_W'(idx);
            if (eligible_i[idx_w]) begin
                grant_o       = idx_w;
                grant_valid_o = 1'b1;
            end
        end
        if (hold_i && eligible_i[last_grant_i]) begin
            grant_o       = last_grant_i;
            grant_valid_o = 1'b1;
        end
    end

endmodule

// File: rtl/task_dispatcher.sv
// Round-robin dispatcher. It pops one task at a time from NUM_Q queues,
// registers the task, and offers it to a single worker.
module task_dispatcher
    import task_sched_pkg::*;
#(
    parameter int NUM_Q = 4,
    parameter int QID_W = qid_width(NUM_Q),
    parameter int BURST = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_Q-1:0]        q_mask,
    input  logic [NUM_Q-1:0]        q_empty,
    input  logic [NUM_Q*TASK_W-1:0] q_task,
    output logic [NUM_Q-1:0]        q_pop,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TASK_W-1:0]       out_task,
    output logic [QID_W-1:0]        out_qid,
    output logic                    busy,
    output logic [15:0]             dispatch_count
);

    localparam logic [3:0] BURST_MAX = 4'(BURST - 1);

    state_e            state_q, state_d;
    logic [QID_W-1:0]  last_grant_q, last_grant_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic              started_q, started_d;
    logic [TASK_W-1:0] out_task_q, out_task_d;
    logic [QID_W-1:0]  out_qid_q, out_qid_d;
    logic [15:0]       count_q, count_d;

    logic [NUM_Q-1:0]  eligible;
    logic              hold;
    logic [QID_W-1:0]  grant;
    logic              grant_valid;
    logic              pop_opp;
    logic              do_pop;

    assign eligible = ~q_empty & ~q_mask;
    // The reset value of last_grant only seeds the search.
    // started_q prevents it from being held on the very first grant.
    assign hold     = started_q && (burst_cnt_q < BURST_MAX);
    assign pop_opp  = enable && grant_valid && !rst;

    rr_arbiter #(
        .NUM_Q (NUM_Q),
        .QID_W (QID_W)
    ) u_arb (
        .eligible_i    (eligible),
        .last_grant_i  (last_grant_q),
        .hold_i        (hold),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        started_d    = started_q;
        out_task_d   = out_task_q;
        out_qid_d    = out_qid_q;
        count_d      = count_q;
        do_pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop_opp) begin
                    do_pop  = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    count_d = count_q + 16'd1;
                    if (pop_opp) do_pop  = 1'b1;
                    else         state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_pop) begin
            out_task_d   = q_task[int'(grant)*TASK_W +: TASK_W];
            out_qid_d    = grant;
            last_grant_d = grant;
            started_d    = 1'b1;
            if (grant == last_grant_q)
                burst_cnt_d = (burst_cnt_q < BURST_MAX) ? burst_cnt_q + 4'd1 : burst_cnt_q;
            else
                burst_cnt_d = 4'd0;
        end
    end

    assign q_pop = do_pop ? (NUM_Q'(1) << grant) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= QID_W'(NUM_Q - 1);
            burst_cnt_q  <= 4'd0;
            started_q    <= 1'b0;
            out_task_q   <= '0;
            out_qid_q    <= '0;
            count_q      <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            started_q    <= started_d;
            out_task_q   <= out_task_d;
            out_qid_q    <= out_qid_d;
            count_q      <= count_d;
        end
    end

    assign out_valid      = (state_q == OFFER);
    assign busy           = (state_q == OFFER);
    assign out_task       = out_task_q;
    assign out_qid        = out_qid_q;
    assign dispatch_count = count_q;

endmodule

// File: doc/task_dispatcher.md
# task_dispatcher

Round-robin dispatcher that drains NUM_Q independent task FIFOs and hands one task at a time to a single worker over a valid/ready handshake. It sits between the bank of per-requester task queues (8-bit tasks, combinational head-of-queue output, one-cycle pop) and the execution unit. It decides which queue to pop, registers the popped task with its queue ID, and holds it stable until the worker accepts it. Sustained throughput is one task per clock.

## Interface
- NUM_Q, 4, number of task queues served (2..16)
- QID_W, 2, width of queue ID, equal to clog2(NUM_Q)
- BURST, 2, maximum consecutive grants to one queue before the pointer must rotate (1..15)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  when low, no new pops; a task already held is still offered
- q_mask  in  NUM_Q  bit i high excludes queue i from arbitration
- q_empty  in  NUM_Q  empty flag of queue i
- q_task  in  NUM_Q*8  head task of queue i, at bits [8i+7:8i]
- q_pop  out  NUM_Q  one-hot pop strobe, combinational, at most one bit high per cycle
- out_valid  out  1  out_task/out_qid hold a task; reset 0
- out_ready  in  1  worker accepts when out_valid && out_ready
- out_task  out  8  dispatched task, registered; reset 0
- out_qid  out  QID_W  source queue of out_task; reset 0
- busy  out  1  high when state is OFFER; reset 0
- dispatch_count  out  16  accepted-task counter, wraps at 2^16; reset 0

## Operation
- Eligible(i) = !q_empty[i] && !q_mask[i]. A pop opportunity exists when enable is high and any queue is eligible.
- Registers: last_grant (QID_W, reset NUM_Q-1), burst_cnt (4 bit, reset 0), state, output registers.
- Grant selection:
  - If burst_cnt < BURST-1 and Eligible(last_grant), grant last_grant.
  - Otherwise, grant the first eligible queue searching last_grant+1, last_grant+2, … modulo NUM_Q.
  - After reset, queue 0 has first priority.
- On a pop, the following happen in the same cycle:
  - q_pop[g]=1.
  - out_task <= q_task[g], out_qid <= g.
  - If g==last_grant, burst_cnt <= burst_cnt+1; otherwise burst_cnt <= 0.
  - last_grant <= g.
- FSM states:
  - IDLE: out_valid=0. If a pop opportunity exists, pop and go to OFFER. Otherwise stay in IDLE.
  - OFFER: out_valid=1. Without out_ready, hold all outputs and do not pop. With out_ready:
    - dispatch_count increments.
    - If a pop opportunity exists, pop in the same cycle and stay in OFFER (back-to-back).
    - Otherwise go to IDLE.
- Boundary conditions:
  - A queue is never popped while empty or masked.
  - Changes to enable or q_mask during OFFER do not affect the held task.
  - A queue that empties on the pop cycle is seen as empty on the next cycle (its q_empty is registered). It is therefore never double-popped.
  - All eligible queues except the current one empty: the current queue is served up to BURST times, then the search wraps around and may legitimately grant the same queue again. In that case burst_cnt is still incremented, and it saturates at BURST-1.
  - Reset mid-OFFER: the held task is discarded, outputs return to reset values, and no pop is issued during reset.

## Timing
- Latency: an eligible queue appearing while the dispatcher is in IDLE pops in that same cycle, and out_valid rises on the next edge.
- Throughput: one task per cycle while out_ready=1 and tasks remain.
- q_pop depends combinationally on q_empty, q_mask, enable, out_ready and state. It has no dependency on out_task.
- All other outputs are registered.

## Structure
- Package task_sched_pkg holds:
  - TASK_W=8.
  - The state enum {IDLE, OFFER}.
  - A function computing the QID width.
- Sub-module rr_arbiter:
  - Inputs: eligible vector, last_grant, burst-hold flag.
  - Outputs: grant index and grant valid.
  - Purely combinational rotating-priority search.
- Top-level task_dispatcher contains the FSM, the output registers, burst_cnt and dispatch_count.

## Test plan
- Reset, all queues empty, enable=1: out_valid=0, q_pop=0, busy=0, and dispatch_count stays 0 for 20 cycles.
- Queues 0–3 each hold 2 tasks, BURST=1, out_ready=1: out_qid sequence is 0,1,2,3,0,1,2,3, one per cycle. dispatch_count ends at 8.
- BURST=2, same load: out_qid sequence is 0,0,1,1,2,2,3,3.
- Queue 2 holds task 0xA5, out_ready held low 10 cycles: exactly one q_pop[2] pulse. out_task=0xA5 and out_qid=2 stay stable. On out_ready=1, dispatch_count becomes 1 and the FSM returns to IDLE.
- q_mask=4'b0010 with all queues loaded: q_pop[1] never asserts. Clearing the mask causes queue 1 to be granted in its round-robin turn.
- Assert rst during OFFER holding 0x3C: out_valid=0, out_task=0, and dispatch_count=0 immediately. The task is not re-offered, and arbitration restarts at queue 0.
